// File: rtl/ps2_tx_if.sv
// Handshake bundle between a command source and the PS/2 host transmitter.
// The master side issues write strobes and data.
// The slave side (ps2_tx) reports idle, done and error status.
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err_tick;

    modport master (
        output wr_ps2,
        output din,
        input  tx_idle,
        input  tx_done_tick,
        input  tx_err_tick
    );

    modport slave (
        input  wr_ps2,
        input  din,
        output tx_idle,
        output tx_done_tick,
        output tx_err_tick
    );
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// It pulls ps2c low for a request-to-send period, then shifts out the frame:
// start bit, d0..d7 (LSB first), odd parity and stop bit. Each bit follows the
// device's clock. Both bus lines are open-collector: they are driven 0 or released.
// Optional feature macro: PS2_TX_ACK_CHECK_EN. When it is defined, the device's
// acknowledge bit is checked after the stop bit, and a missing acknowledge
// raises tx_err_tick.
module ps2_tx #(
    parameter int RTS_CYCLES = 10000
) (
    input  logic    clk,
    input  logic    reset,
    ps2_tx_if.slave bus,
    inout  wire     ps2c,
    inout  wire     ps2d
);

`ifdef PS2_TX_ACK_CHECK_EN
    typedef enum logic [2:0] {idle, rts, start, data, stop, ack_wait} state_t;
`else
    typedef enum logic [2:0] {idle, rts, start, data, stop} state_t;
`endif

    localparam logic [13:0] RTS_LOAD = 14'(RTS_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [7:0]  filter_reg, filter_next;
    logic        f_ps2c_reg, f_ps2c_next;
    logic [3:0]  n_reg, n_next;
    logic [8:0]  b_reg, b_next;
    logic [13:0] c_reg, c_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        fall_edge;
    logic        drive_c;
    logic        drive_d;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= idle;
            filter_reg <= 8'h00;
            f_ps2c_reg <= 1'b0;
            n_reg      <= 4'd0;
            b_reg      <= 9'd0;
            c_reg      <= 14'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            filter_reg <= filter_next;
            f_ps2c_reg <= f_ps2c_next;
            n_reg      <= n_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    // Debounce ps2c: the filtered level only changes after 8 identical samples
    always_comb begin
        filter_next = {ps2c, filter_reg[7:1]};
        if (filter_reg == 8'hFF)
            f_ps2c_next = 1'b1;
        else if (filter_reg == 8'h00)
            f_ps2c_next = 1'b0;
        else
            f_ps2c_next = f_ps2c_reg;
    end

    assign fall_edge = f_ps2c_reg & ~f_ps2c_next;

    // Frame sequencing: next state, counters, line drive and completion ticks
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        drive_c    = 1'b0;
        drive_d    = 1'b0;
        case (state_reg)
            idle: begin
                // A write arriving on the same cycle as a completion tick is dropped
                if (bus.wr_ps2 && !done_reg && !err_reg) begin
                    b_next     = {~^bus.din, bus.din};
                    c_next     = RTS_LOAD;
                    state_next = rts;
                end
            end
            rts: begin
                drive_c = 1'b1;
                if (c_reg == 14'd0)
                    state_next = start;
                else
                    c_next = c_reg - 14'd1;
            end
            start: begin
                drive_d = 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = data;
                end
            end
            data: begin
                drive_d = ~b_reg[0];
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = stop;
                    else
                        n_next = n_reg - 4'd1;
                end
            end
            stop: begin
                if (fall_edge) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (ps2d == 1'b0) begin
                        state_next = ack_wait;
                    end else begin
                        err_next   = 1'b1;
                        state_next = idle;
                    end
`else
                    done_next  = 1'b1;
                    state_next = idle;
`endif
                end
            end
`ifdef PS2_TX_ACK_CHECK_EN
            ack_wait: begin
                if (f_ps2c_reg && ps2d) begin
                    done_next  = 1'b1;
                    state_next = idle;
                end
            end
`endif
            default: begin
                state_next = idle;
            end
        endcase
    end

    assign ps2c = drive_c ? 1'b0 : 1'bz;
    assign ps2d = drive_d ? 1'b0 : 1'bz;

    assign bus.tx_idle      = (state_reg == idle);
    assign bus.tx_done_tick = done_reg;
`ifdef PS2_TX_ACK_CHECK_EN
    assign bus.tx_err_tick  = err_reg;
`else
    assign bus.tx_err_tick  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// Testbench for ps2_tx.
// A behavioural PS/2 device answers each request-to-send and clocks in the
// frame. The bits it captures are checked against frames the bench queued
// when it issued each write.
`timescale 1ns/1ps
module tb_ps2_tx;
    localparam int RTS  = 16;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   dev_c_low = 1'b0;
    bit   dev_d_low = 1'b0;
    wire  ps2c;
    wire  ps2d;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_tx_if bus_if ();

    ps2_tx #(.RTS_CYCLES(RTS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .ps2c  (ps2c),
        .ps2d  (ps2d)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;
    int   err_count = 0;
    logic exp_q[$];

    // Count completion and error ticks
    always @(negedge clk) begin
        if (bus_if.tx_done_tick === 1'b1) done_count++;
        if (bus_if.tx_err_tick === 1'b1) err_count++;
    end

    // Queue the 11 wire bits the device should see for byte d
    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(~^d);
        exp_q.push_back(1'b1);
    endtask

    // Pop nbits expected bits, with the first bit in the lowest position
    function automatic logic [10:0] pop_frame(input int nbits);
        logic [10:0] v;
        v = '0;
        for (int i = 0; i < nbits; i++) begin
            if (exp_q.size() > 0) v[i] = exp_q.pop_front();
            else v[i] = 1'bx;
        end
        return v;
    endfunction

    // Issue a single-cycle write strobe
    task automatic write_byte(input logic [7:0] d);
        @(negedge clk);
        bus_if.din    = d;
        bus_if.wr_ps2 = 1'b1;
        @(posedge clk);
        #1;
        bus_if.wr_ps2 = 1'b0;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    // Device model.
    // It waits for the start condition, counting the RTS low cycles on the way.
    // It then clocks n_pulses pulses and samples ps2d at the end of each low phase.
    // It can acknowledge after the stop bit and can inject 3-cycle clock glitches.
    task automatic device_frame(input int n_pulses, input bit ack, input bit glitch,
                                input bit keep_ack, output logic [10:0] bits,
                                output int rts_len, output bit timed_out);
        int guard;
        bits = '0;
        rts_len = 0;
        timed_out = 1'b1;
        guard = 0;
        while (guard < 3000) begin
            @(negedge clk);
            guard++;
            if (ps2c === 1'b1 && ps2d === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            if (ps2c === 1'b0) rts_len++;
        end
        if (timed_out) return;
        bits[0] = ps2d;
        for (int p = 1; p <= n_pulses; p++) begin
            for (int i = 0; i < HALF; i++) begin
                @(negedge clk);
                if (p == 11 && ack && i == 0) dev_d_low = 1'b1;
                if (glitch && p >= 3 && p <= 8)
                    dev_c_low = (i >= HALF / 2) && (i < HALF / 2 + 3);
            end
            dev_c_low = 1'b1;
            for (int i = 0; i < HALF; i++) @(negedge clk);
            if (p <= 10) bits[p] = ps2d;
            dev_c_low = 1'b0;
        end
        if (!keep_ack) dev_d_low = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int t0, input int budget);
        for (int i = 0; i < budget && done_count == t0; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (bus_if.tx_idle !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_idle: got %b expected 1", bus_if.tx_idle);
        end
        checks++;
        if (bus_if.tx_done_tick !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus_if.tx_done_tick);
        end
        checks++;
        if (bus_if.tx_err_tick !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus_if.tx_err_tick);
        end
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_lines: got c=%b d=%b expected both 1", ps2c, ps2d);
        end
    endtask

    task automatic test_command;
        logic [10:0] bits, exp;
        int rl, t0, e0;
        bit to;
        t0 = done_count;
        e0 = err_count;
        push_frame(8'hF4);
        write_byte(8'hF4);
        checks++;
        if (bus_if.tx_idle !== 1'b0 || ps2c !== 1'b0) begin
            errors++; $display("[TB] FAIL cmd_accept: got idle=%b c=%b expected idle=0 c=0", bus_if.tx_idle, ps2c);
        end
        device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
        checks++;
        if (to) begin
            errors++; $display("[TB] FAIL cmd_start_timeout: got timeout expected start bit");
        end
        checks++;
        if (rl != RTS) begin
            errors++; $display("[TB] FAIL cmd_rts_len: got %0d expected %0d", rl, RTS);
        end
        exp = pop_frame(11);
        checks++;
        if (bits !== exp) begin
            errors++; $display("[TB] FAIL cmd_frame: got %b expected %b", bits, exp);
        end
        checks++;
        if (bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            errors++; $display("[TB] FAIL cmd_wire_bits: got %b expected 10111101000", bits);
        end
        wait_done(t0, 200);
        settle(100);
        checks++;
        if (done_count - t0 != 1) begin
            errors++; $display("[TB] FAIL cmd_done_count: got %0d expected 1", done_count - t0);
        end
        checks++;
        if (err_count != e0 || bus_if.tx_idle !== 1'b1) begin
            errors++; $display("[TB] FAIL cmd_end_state: got err=%0d idle=%b expected err=0 idle=1", err_count - e0, bus_if.tx_idle);
        end
    endtask

    task automatic test_parity;
        logic [7:0]  bytes [3];
        logic        par [3];
        logic [10:0] bits, exp;
        int rl, t0;
        bit to;
        bytes[0] = 8'h00; par[0] = 1'b1;
        bytes[1] = 8'hFF; par[1] = 1'b1;
        bytes[2] = 8'h01; par[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t0 = done_count;
            push_frame(bytes[k]);
            write_byte(bytes[k]);
            device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
            exp = pop_frame(11);
            checks++;
            if (to || bits !== exp) begin
                errors++; $display("[TB] FAIL parity_frame_%0h: got %b expected %b", bytes[k], bits, exp);
            end
            checks++;
            if (bits[9] !== par[k]) begin
                errors++; $display("[TB] FAIL parity_bit_%0h: got %b expected %b", bytes[k], bits[9], par[k]);
            end
            wait_done(t0, 200);
            settle(50);
            checks++;
            if (done_count - t0 != 1) begin
                errors++; $display("[TB] FAIL parity_done_%0h: got %0d expected 1", bytes[k], done_count - t0);
            end
        end
    endtask

    task automatic test_busy_writes;
        logic [10:0] bits, exp;
        int rl, t0;
        bit to;
        t0 = done_count;
        push_frame(8'h3C);
        write_byte(8'h3C);
        fork
            device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
            begin
                settle(5);
                write_byte(8'hAA);
                settle(300);
                write_byte(8'hAA);
            end
        join
        exp = pop_frame(11);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL busy_frame: got %b expected %b", bits, exp);
        end
        wait_done(t0, 200);
        settle(150);
        checks++;
        if (done_count - t0 != 1) begin
            errors++; $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count - t0);
        end
        checks++;
        if (bus_if.tx_idle !== 1'b1 || ps2c !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_no_restart: got idle=%b c=%b expected 1 1", bus_if.tx_idle, ps2c);
        end
    endtask

    task automatic test_glitch;
        logic [10:0] bits, exp;
        int rl, t0;
        bit to;
        t0 = done_count;
        push_frame(8'hC3);
        write_byte(8'hC3);
        device_frame(11, 1'b1, 1'b1, 1'b0, bits, rl, to);
        exp = pop_frame(11);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL glitch_frame: got %b expected %b", bits, exp);
        end
        wait_done(t0, 200);
        settle(50);
        checks++;
        if (done_count - t0 != 1) begin
            errors++; $display("[TB] FAIL glitch_done_count: got %0d expected 1", done_count - t0);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] bits, exp;
        int rl, t0;
        bit to, seen;
        t0 = done_count;
        seen = 1'b0;
        push_frame(8'hA5);
        write_byte(8'hA5);
        fork
            device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge clk);
                    if (bus_if.tx_done_tick === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    bus_if.din    = 8'h3C;
                    bus_if.wr_ps2 = 1'b1;
                    @(negedge clk);
                    checks++;
                    if (bus_if.tx_idle !== 1'b1) begin
                        errors++; $display("[TB] FAIL b2b_tick_write_ignored: got idle=%b expected 1", bus_if.tx_idle);
                    end
                    bus_if.din = 8'h81;
                    push_frame(8'h81);
                    @(posedge clk);
                    #1;
                    bus_if.wr_ps2 = 1'b0;
                    checks++;
                    if (bus_if.tx_idle !== 1'b0) begin
                        errors++; $display("[TB] FAIL b2b_next_write_taken: got idle=%b expected 0", bus_if.tx_idle);
                    end
                end
            end
        join
        checks++;
        if (!seen) begin
            errors++; $display("[TB] FAIL b2b_done_timeout: got no tick expected tick");
        end
        exp = pop_frame(11);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL b2b_first_frame: got %b expected %b", bits, exp);
        end
        t0 = done_count;
        device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
        exp = pop_frame(11);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL b2b_second_frame: got %b expected %b", bits, exp);
        end
        wait_done(t0, 200);
        settle(50);
        checks++;
        if (done_count - t0 != 1) begin
            errors++; $display("[TB] FAIL b2b_second_done: got %0d expected 1", done_count - t0);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] bits, exp;
        int rl, t0, e0;
        bit to;
        push_frame(8'h96);
        write_byte(8'h96);
        device_frame(4, 1'b0, 1'b0, 1'b0, bits, rl, to);
        exp = pop_frame(5);
        checks++;
        if (to || bits[4:0] !== exp[4:0]) begin
            errors++; $display("[TB] FAIL rst_partial_bits: got %b expected %b", bits[4:0], exp[4:0]);
        end
        exp_q.delete();
        t0 = done_count;
        e0 = err_count;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1 || bus_if.tx_idle !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_release: got c=%b d=%b idle=%b expected 1 1 1", ps2c, ps2d, bus_if.tx_idle);
        end
        reset = 1'b0;
        settle(100);
        checks++;
        if (done_count != t0 || err_count != e0) begin
            errors++; $display("[TB] FAIL rst_mid_no_tick: got done=%0d err=%0d expected 0 0", done_count - t0, err_count - e0);
        end
        t0 = done_count;
        push_frame(8'h55);
        write_byte(8'h55);
        device_frame(11, 1'b1, 1'b0, 1'b0, bits, rl, to);
        exp = pop_frame(11);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL rst_then_55: got %b expected %b", bits, exp);
        end
        wait_done(t0, 200);
        settle(50);
        checks++;
        if (done_count - t0 != 1) begin
            errors++; $display("[TB] FAIL rst_then_55_done: got %0d expected 1", done_count - t0);
        end
    endtask

    task automatic test_reset_with_write;
        @(negedge clk);
        reset = 1'b1;
        bus_if.din = 8'h77;
        bus_if.wr_ps2 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_if.wr_ps2 = 1'b0;
        settle(5);
        checks++;
        if (bus_if.tx_idle !== 1'b1 || ps2c !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_wr_lost: got idle=%b c=%b expected 1 1", bus_if.tx_idle, ps2c);
        end
    endtask

`ifdef PS2_TX_ACK_CHECK_EN
    task automatic test_ack;
        logic [10:0] bits, exp;
        int rl, t0, e0;
        bit to;
        t0 = done_count;
        e0 = err_count;
        push_frame(8'h12);
        write_byte(8'h12);
        device_frame(11, 1'b0, 1'b0, 1'b0, bits, rl, to);
        exp = pop_frame(11);
        settle(50);
        checks++;
        if (to || bits !== exp) begin
            errors++; $display("[TB] FAIL nack_frame: got %b expected %b", bits, exp);
        end
        checks++;
        if (err_count - e0 != 1 || done_count != t0) begin
            errors++; $display("[TB] FAIL nack_ticks: got err=%0d done=%0d expected 1 0", err_count - e0, done_count - t0);
        end
        t0 = done_count;
        e0 = err_count;
        push_frame(8'h34);
        write_byte(8'h34);
        device_frame(11, 1'b1, 1'b0, 1'b1, bits, rl, to);
        exp = pop_frame(11);
        settle(40);
        checks++;
        if (done_count != t0 || bus_if.tx_idle !== 1'b0) begin
            errors++; $display("[TB] FAIL ack_wait_hold: got done=%0d idle=%b expected 0 0", done_count - t0, bus_if.tx_idle);
        end
        dev_d_low = 1'b0;
        wait_done(t0, 200);
        settle(20);
        checks++;
        if (done_count - t0 != 1 || err_count != e0 || bits !== exp) begin
            errors++; $display("[TB] FAIL ack_done: got done=%0d err=%0d bits=%b expected 1 0 %b", done_count - t0, err_count - e0, bits, exp);
        end
    endtask
`endif

    initial begin
        bus_if.wr_ps2 = 1'b0;
        bus_if.din    = 8'h00;
        reset         = 1'b1;
        settle(3);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        settle(20);
        test_command();
        test_parity();
        test_busy_writes();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_with_write();
`ifdef PS2_TX_ACK_CHECK_EN
        test_ack();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit in case a wait never resolves
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
